// File: rtl/stream_fifo_engine.sv
// ---------------------------------------------------------------------------
// stream_fifo_engine
//
// Parametrised FIFO core that sits behind the 8-pin user-module wrapper. It
// supports three operating modes plus a clear mode, all selected by `mode`:
//   00 CONFIG   : synchronous clear of pointers, shifters, rdata and flags
//   01 SERIAL   : bit-serial in (sin, MSB first) / bit-serial out (sout)
//   10 PARALLEL : word-wide in (wdata) / word-wide out (rdata)
//   11 CYCLE    : ring playback, the oldest word is re-appended every edge
//
// Ports
//   myclock              : single clock, all state updates on rising edge
//   resetn               : asynchronous active-low reset
//   mode[1:0]            : operating mode (see above)
//   push, pop            : write / read strobes (SERIAL and PARALLEL only)
//   sin                  : serial data in, MSB first
//   wdata[WORDSIZE-1:0]  : parallel write data
//   rdata[WORDSIZE-1:0]  : last word read, registered
//   sout                 : serial data out, MSB first
//   count[WIDTH:0]       : occupancy 0..DEPTH
//   empty, full, afull   : count==0, count==DEPTH, count>=AFULL
//   overflow, underflow  : sticky error flags
// ---------------------------------------------------------------------------
module stream_fifo_engine #(
    parameter int   WORDSIZE = 4,
    parameter int   DEPTH    = 8,
    parameter int   AFULL    = 6,
    localparam int  WIDTH    = $clog2(DEPTH)
) (
    input  logic                myclock,
    input  logic                resetn,
    input  logic [1:0]          mode,
    input  logic                push,
    input  logic                pop,
    input  logic                sin,
    input  logic [WORDSIZE-1:0] wdata,
    output logic [WORDSIZE-1:0] rdata,
    output logic                sout,
    output logic [WIDTH:0]      count,
    output logic                empty,
    output logic                full,
    output logic                afull,
    output logic                overflow,
    output logic                underflow
);

    typedef enum logic [1:0] {
        MODE_CONFIG   = 2'b00,
        MODE_SERIAL   = 2'b01,
        MODE_PARALLEL = 2'b10,
        MODE_CYCLE    = 2'b11
    } mode_t;

    localparam logic [WIDTH:0] PTR_ONE = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] DEPTH_C = (WIDTH+1)'(DEPTH);
    localparam logic [WIDTH:0] AFULL_C = (WIDTH+1)'(AFULL);

    // Storage (not reset) and state registers
    logic [WORDSIZE-1:0] r_mem [DEPTH];
    logic [WIDTH:0]      r_wptr;
    logic [WIDTH:0]      r_rptr;
    logic [WORDSIZE-1:0] r_ishift;
    logic [WORDSIZE-1:0] r_oshift;
    logic [WORDSIZE-1:0] r_rdata;
    logic                r_overflow;
    logic                r_underflow;

    mode_t               w_mode;
    logic [WIDTH-1:0]    w_widx;
    logic [WIDTH-1:0]    w_ridx;
    logic [WORDSIZE-1:0] w_rword;
    logic [WORDSIZE-1:0] w_serial_word;
    logic [WORDSIZE-1:0] w_mem_wdata;
    logic [WIDTH:0]      w_count;
    logic                w_empty;
    logic                w_full;
    logic                w_active;
    logic                w_pop_acc;
    logic                w_push_acc;
    logic                w_cyc_step;
    logic                w_mem_we;
    logic                w_ovf_evt;
    logic                w_unf_evt;

    assign w_mode  = mode_t'(mode);
    assign w_widx  = r_wptr[WIDTH-1:0];
    assign w_ridx  = r_rptr[WIDTH-1:0];
    assign w_rword = r_mem[w_ridx];

    // The extra wrap bit makes wptr-rptr an exact occupancy, including DEPTH.
    assign w_count = r_wptr - r_rptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == DEPTH_C);

    // The word a serial push stores includes the sin sample of this same edge.
    assign w_serial_word = {r_ishift[WORDSIZE-2:0], sin};

    // Accept rules: a pop frees a slot in the same edge, so a full FIFO can
    // still take a push when the pop goes through.
    assign w_active   = (w_mode == MODE_SERIAL) || (w_mode == MODE_PARALLEL);
    assign w_pop_acc  = w_active && pop && !w_empty;
    assign w_push_acc = w_active && push && (!w_full || w_pop_acc);
    assign w_cyc_step = (w_mode == MODE_CYCLE) && !w_empty;
    assign w_ovf_evt  = w_active && push && w_full && !w_pop_acc;
    assign w_unf_evt  = w_active && pop && w_empty;

    assign w_mem_we = w_push_acc || w_cyc_step;

    always_comb begin
        w_mem_wdata = wdata;
        case (w_mode)
            MODE_SERIAL: w_mem_wdata = w_serial_word;
            MODE_CYCLE:  w_mem_wdata = w_rword;   // re-append the oldest word
            default:     w_mem_wdata = wdata;
        endcase
    end

    // Memory write port. When full, wptr and rptr share an index; the read
    // side still sees the old word because reads are taken from the register
    // state before this edge.
    always_ff @(posedge myclock) begin
        if (w_mem_we) begin
            r_mem[w_widx] <= w_mem_wdata;
        end
    end

    always_ff @(posedge myclock or negedge resetn) begin
        if (!resetn) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_ishift    <= '0;
            r_oshift    <= '0;
            r_rdata     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_mode == MODE_CONFIG) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_ishift    <= '0;
            r_oshift    <= '0;
            r_rdata     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_acc || w_cyc_step) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop_acc || w_cyc_step) begin
                r_rptr  <= r_rptr + PTR_ONE;
                r_rdata <= w_rword;
            end
            // Shifters only move in SERIAL mode; they hold otherwise.
            if (w_mode == MODE_SERIAL) begin
                r_ishift <= w_serial_word;
                if (w_pop_acc) begin
                    r_oshift <= w_rword;
                end else begin
                    r_oshift <= {r_oshift[WORDSIZE-2:0], 1'b0};
                end
            end
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
            if (w_unf_evt) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign rdata     = r_rdata;
    assign sout      = r_oshift[WORDSIZE-1];
    assign count     = w_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign afull     = (w_count >= AFULL_C);
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_stream_fifo_engine.sv
// ---------------------------------------------------------------------------
// tb_stream_fifo_engine
//
// Self-checking bench for stream_fifo_engine (WORDSIZE=4, DEPTH=8, AFULL=6).
// A queue-based reference model tracks stored words, rdata, the serial output
// bit stream and the sticky flags; every output is compared after each edge.
// Directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_stream_fifo_engine;

    localparam int WS = 4;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int W  = $clog2(D);

    logic          myclock;
    logic          resetn;
    logic [1:0]    mode;
    logic          push;
    logic          pop;
    logic          sin;
    logic [WS-1:0] wdata;
    logic [WS-1:0] rdata;
    logic          sout;
    logic [W:0]    count;
    logic          empty;
    logic          full;
    logic          afull;
    logic          overflow;
    logic          underflow;

    stream_fifo_engine #(
        .WORDSIZE (WS),
        .DEPTH    (D),
        .AFULL    (AF)
    ) dut (
        .myclock   (myclock),
        .resetn    (resetn),
        .mode      (mode),
        .push      (push),
        .pop       (pop),
        .sin       (sin),
        .wdata     (wdata),
        .rdata     (rdata),
        .sout      (sout),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .afull     (afull),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial myclock = 1'b0;
    always #5 myclock = ~myclock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_q[$];       // stored words, oldest first
    int m_rdata;
    int m_hist;       // last WS serial samples
    int m_obits[$];   // serial output bits still to appear on sout
    bit m_ovf;
    bit m_unf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_obits.delete();
        m_rdata = 0;
        m_hist  = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic model_edge(input logic [1:0] m, input logic pu, input logic po,
                              input logic si, input logic [WS-1:0] wd);
        int  w;
        int  win;
        bit  pa;
        bit  pacc;
        int  mask;
        mask = (1 << WS) - 1;
        if (m == 2'b00) begin
            model_reset();
        end else if (m == 2'b11) begin
            if (m_q.size() > 0) begin
                w = m_q.pop_front();
                m_rdata = w;
                m_q.push_back(w);
            end
        end else begin
            pa   = po && (m_q.size() > 0);
            pacc = pu && ((m_q.size() < D) || pa);
            if (pu && (m_q.size() == D) && !pa) m_ovf = 1'b1;
            if (po && (m_q.size() == 0)) m_unf = 1'b1;
            if (m == 2'b10) win = int'(wd);
            else            win = ((m_hist << 1) | int'(si)) & mask;
            if (pa) begin
                w = m_q.pop_front();
                m_rdata = w;
                if (m == 2'b01) begin
                    m_obits.delete();
                    for (int b = WS - 1; b >= 0; b--) m_obits.push_back((w >> b) & 1);
                end
            end else if (m == 2'b01) begin
                if (m_obits.size() > 0) void'(m_obits.pop_front());
            end
            if (pacc) m_q.push_back(win);
            if (m == 2'b01) m_hist = win;
        end
    endtask

    task automatic check_outputs();
        int exp_sout;
        exp_sout = (m_obits.size() > 0) ? m_obits[0] : 0;
        check_val("count",     32'(count),     32'(m_q.size()));
        check_val("empty",     32'(empty),     32'(m_q.size() == 0));
        check_val("full",      32'(full),      32'(m_q.size() == D));
        check_val("afull",     32'(afull),     32'(m_q.size() >= AF));
        check_val("rdata",     32'(rdata),     32'(m_rdata));
        check_val("sout",      32'(sout),      32'(exp_sout));
        check_val("overflow",  32'(overflow),  32'(m_ovf));
        check_val("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic [1:0] m, input logic pu, input logic po,
                        input logic si, input logic [WS-1:0] wd);
        mode  = m;
        push  = pu;
        pop   = po;
        sin   = si;
        wdata = wd;
        model_edge(m, pu, po, si, wd);
        @(posedge myclock);
        #1;
        check_outputs();
    endtask

    logic [WS-1:0] cyc_seq [3];
    logic [3:0]    ser_bits;

    initial begin
        resetn = 1'b0;
        mode   = 2'b00;
        push   = 1'b0;
        pop    = 1'b0;
        sin    = 1'b0;
        wdata  = '0;
        model_reset();
        #12;
        check_outputs();
        resetn = 1'b1;

        // PARALLEL fill 1..8, overflow on the 9th push, drain, underflow.
        for (int i = 1; i <= D; i++) step(2'b10, 1'b1, 1'b0, 1'b0, WS'(i));
        step(2'b10, 1'b1, 1'b0, 1'b0, WS'(9));
        for (int i = 1; i <= D; i++) begin
            step(2'b10, 1'b0, 1'b1, 1'b0, '0);
            check_val("drain_order", 32'(rdata), 32'(i));
        end
        step(2'b10, 1'b0, 1'b1, 1'b0, '0);

        // Simultaneous push/pop on empty (underflow, push kept) and on full.
        step(2'b00, 1'b0, 1'b0, 1'b0, '0);
        step(2'b10, 1'b1, 1'b1, 1'b0, 4'hA);
        for (int i = 0; i < D - 1; i++) step(2'b10, 1'b1, 1'b0, 1'b0, WS'(i + 3));
        step(2'b10, 1'b1, 1'b1, 1'b0, 4'hF);
        check_val("full_pp_rdata", 32'(rdata), 32'h A);

        // Async reset mid-stream: outputs clear with no clock edge.
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #2;
        resetn = 1'b1;

        // Fill 3 words then one CONFIG cycle.
        for (int i = 0; i < 3; i++) step(2'b10, 1'b1, 1'b0, 1'b0, WS'(i + 1));
        step(2'b00, 1'b1, 1'b1, 1'b0, '0);

        // SERIAL: sin 1,0,1,1 with push on the 4th bit, then pop and watch sout.
        ser_bits = 4'b1011;
        for (int i = 3; i >= 0; i--) step(2'b01, (i == 0), 1'b0, ser_bits[i], '0);
        step(2'b01, 1'b0, 1'b1, 1'b0, '0);
        check_val("ser_word", 32'(rdata), 32'h B);
        for (int i = 0; i < WS + 2; i++) step(2'b01, 1'b0, 1'b0, 1'b0, '0);

        // CYCLE playback of 3,5,9 with random strobes that must be ignored.
        step(2'b00, 1'b0, 1'b0, 1'b0, '0);
        cyc_seq[0] = 4'h3;
        cyc_seq[1] = 4'h5;
        cyc_seq[2] = 4'h9;
        for (int i = 0; i < 3; i++) step(2'b10, 1'b1, 1'b0, 1'b0, cyc_seq[i]);
        for (int i = 0; i < 6; i++) begin
            step(2'b11, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, WS'($urandom));
            check_val("cyc_rdata", 32'(rdata), 32'(cyc_seq[i % 3]));
        end

        // Wrap-around: hold occupancy near 7 with paired push/pop.
        step(2'b00, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 7; i++) step(2'b10, 1'b1, 1'b0, 1'b0, WS'($urandom));
        for (int i = 0; i < 20; i++) step(2'b10, 1'b1, 1'b1, 1'b0, WS'($urandom));

        // Randomized phase over all modes.
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [1:0] m;
            r = $urandom_range(0, 99);
            if (r < 3)       m = 2'b00;
            else if (r < 50) m = 2'b01;
            else if (r < 85) m = 2'b10;
            else             m = 2'b11;
            step(m, ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 1)), WS'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_fifo_engine.md
# stream_fifo_engine

Parametrised FIFO core that succeeds the fixed 8-entry, 4-bit TinyTapeout FIFO. It supports serial, parallel and cycle (ring-playback) modes with correct full/empty handling, occupancy count, almost-full, and sticky overflow/underflow flags. It sits behind the 8-pin user-module I/O wrapper. Pin decode and config-sequence detection stay in the wrapper, which drives `mode` and the strobes into this core.

## Interface
Parameters:
- `WORDSIZE`, 4: data word width in bits, ≥2.
- `DEPTH`, 8: number of storage words; power of 2, ≥2.
- `AFULL`, 6: almost-full threshold, 1..DEPTH.
- `WIDTH`, $clog2(DEPTH): pointer index width (derived, not overridden).

Ports:
- `myclock` in 1: the single clock; all state updates on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `mode` in 2: 00 CONFIG, 01 SERIAL, 10 PARALLEL, 11 CYCLE.
- `push` in 1: write strobe (SERIAL/PARALLEL).
- `pop` in 1: read strobe (SERIAL/PARALLEL).
- `sin` in 1: serial data in, MSB first.
- `wdata` in WORDSIZE: parallel write data.
- `rdata` out WORDSIZE: last word read, registered.
- `sout` out 1: serial data out, MSB first.
- `count` out WIDTH+1: occupancy, 0..DEPTH.
- `empty`, `full`, `afull` out 1 each: count==0, count==DEPTH, count≥AFULL.
- `overflow`, `underflow` out 1 each: sticky error flags.

## Operation
- Storage: DEPTH×WORDSIZE array. `wptr`/`rptr` are WIDTH+1 bits (extra wrap bit); index = low WIDTH bits; `count` = wptr−rptr (mod 2^(WIDTH+1)).
- Reset (`resetn`=0, async): wptr=rptr=0, `rdata`=0, input/output shifters=0, `overflow`=`underflow`=0. Resulting outputs: `count`=0, `empty`=1, `full`=0, `afull`=0, `sout`=0. Memory contents are not reset.
- CONFIG (00): synchronous clear of the same state as reset, except memory. Strobes are ignored.
- Mode changes between 01/10/11 preserve pointers and contents. The new mode governs the first edge at which `mode` is sampled with the new value.
- Accept rules (SERIAL/PARALLEL):
  - pop is accepted iff `pop` and !empty.
  - push is accepted iff `push` and (!full or pop accepted).
  - Full with push and pop together: both are accepted, count stays DEPTH.
  - Empty with push and pop together: push is accepted, pop is rejected (underflow set).
- PARALLEL: an accepted push writes `wdata` at wptr, then wptr+1. An accepted pop loads `rdata`←mem[rptr], then rptr+1.
- SERIAL:
  - Input shifter shifts left every edge taking `sin` as LSB.
  - An accepted push writes {ishift[WORDSIZE-2:0], sin}, i.e. the last WORDSIZE `sin` samples including the current one.
  - An accepted pop loads `rdata` and the output shifter with mem[rptr]. Otherwise the output shifter shifts left, zero-filling.
  - `sout` = oshift MSB. A pop mid-word abandons the remaining bits.
  - In PARALLEL and CYCLE modes the input shifter holds and the output shifter is not loaded or shifted.
- CYCLE (11): each edge with !empty does `rdata`←mem[rptr], mem[wptr]←mem[rptr], rptr+1, wptr+1; count is unchanged. When empty, nothing changes. `push`/`pop` are ignored; the flags do not change.
- Errors:
  - `overflow` is set on push while full and the pop is not accepted.
  - `underflow` is set on pop while empty.
  - Both are sticky until reset or CONFIG. They are evaluated only in SERIAL/PARALLEL.

## Timing
- `count`, `empty`, `full`, `afull` are combinational from registered pointers. They reflect an accepted op one cycle after its edge.
- `rdata`: 1-cycle latency from an accepted pop (or CYCLE step); it holds its value otherwise.
- `sout`: word MSB is valid in the cycle after the pop edge; bit k is valid k cycles later; it is 0 after WORDSIZE bits unless reloaded.
- Write-to-read: a word pushed at edge t is poppable at edge t+1. There is no fall-through; `rdata` is valid after edge t+1.
- Pointer wrap: index wraps DEPTH−1→0; the wrap bit toggles. No loss at wrap.
- Async reset mid-operation: state clears immediately and outputs reach their reset values without a clock edge. Deassertion is sampled at the next edge.

## Test plan
- Reset/CONFIG: assert `resetn`=0 mid-stream → count=0, empty=1, rdata=0, flags=0 immediately. Fill 3 words, then mode=00 for 1 cycle → count=0, empty=1.
- PARALLEL fill/drain, DEPTH=8: push 1..8 → full=1 and afull=1 once count≥6. A 9th push → overflow=1, count stays 8. Pop ×8 → rdata 1..8 in order, empty=1. Pop again → underflow=1.
- Simultaneous ops:
  - Full with push=pop=1 → count stays 8, no overflow, rdata=oldest word.
  - Empty with push=pop=1 → count=1, underflow=1.
- SERIAL, WORDSIZE=4: drive `sin` 1,0,1,1 with push on the 4th bit → word 0xB stored. A pop → sout yields 1,0,1,1 on the next 4 cycles, then 0.
- CYCLE: load 0x3,0x5,0x9 then mode=11 for 6 cycles → rdata 3,5,9,3,5,9, count stays 3. Strobes are ignored.
- Wrap-around: 20 interleaved push/pop pairs at count≈7 → data order preserved, and no spurious full/empty across the pointer wrap.
